// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - single-entry load/store stage between execute and writeback
module mem_stage_lsu #(
    parameter int XLEN = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [XLEN-1:0]   ex_result,
    input  logic [XLEN-1:0]   ex_sdata,
    input  logic              ex_is_load,
    input  logic              ex_is_store,
    input  logic [1:0]        ex_size,
    input  logic              ex_unsigned,
    input  logic [4:0]        ex_rd,
    input  logic              ex_rd_wen,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [XLEN-1:0]   mem_addr,
    output logic              mem_we,
    output logic [XLEN/8-1:0] mem_wmask,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [4:0]        wb_rd,
    output logic              wb_wen,
    output logic [XLEN-1:0]   wb_data,
    output logic              wb_misalign
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t          state, state_nxt;
    logic            accept, is_mem, misalign, issue;
    logic [NB-1:0]   size_mask;
    logic [OFFW-1:0] off_q;
    logic [1:0]      size_q;
    logic            unsigned_q, load_q, rd_wen_q;
    logic [XLEN-1:0] rdata_sh, load_val;
    logic            ext;

    // ex_ready is gated by rst_n so nothing is accepted while reset is held
    assign ex_ready      = rst_n & ((state == IDLE) | ((state == DONE) & wb_ready));
    assign accept        = ex_valid & ex_ready;
    assign is_mem        = ex_is_load | ex_is_store;
    assign issue         = is_mem & ~misalign;
    assign mem_req_valid = (state == REQ);
    assign wb_valid      = (state == DONE);

    always_comb begin
        misalign = 1'b0;
        case (ex_size)
            2'd1:    misalign = ex_result[0];
            2'd2:    misalign = |ex_result[1:0];
            2'd3:    misalign = |ex_result[2:0];
            default: misalign = 1'b0;
        endcase
    end

    always_comb begin
        size_mask = NB'(1);
        case (ex_size)
            2'd0:    size_mask = NB'(1);
            2'd1:    size_mask = NB'(3);
            2'd2:    size_mask = NB'(15);
            default: size_mask = NB'(255);
        endcase
    end

    always_comb begin
        rdata_sh = mem_rdata >> {off_q, 3'b000};
        ext      = 1'b0;
        load_val = rdata_sh;
        case (size_q)
            2'd0: begin
                ext      = ~unsigned_q & rdata_sh[7];
                load_val = {{(XLEN-8){ext}}, rdata_sh[7:0]};
            end
            2'd1: begin
                ext      = ~unsigned_q & rdata_sh[15];
                load_val = {{(XLEN-16){ext}}, rdata_sh[15:0]};
            end
            2'd2: begin
                ext      = ~unsigned_q & rdata_sh[31];
                load_val = {{(XLEN-32){ext}}, rdata_sh[31:0]};
            end
            default: load_val = rdata_sh;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // DONE with wb_ready doubles as IDLE so a waiting op is taken without a bubble
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = issue ? REQ : DONE;
            REQ:  if (mem_req_ready) state_nxt = WAIT;
            WAIT: if (mem_rsp_valid) state_nxt = DONE;
            DONE: begin
                if (accept)        state_nxt = issue ? REQ : DONE;
                else if (wb_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off_q       <= '0;
            size_q      <= '0;
            unsigned_q  <= 1'b0;
            load_q      <= 1'b0;
            rd_wen_q    <= 1'b0;
            mem_addr    <= '0;
            mem_we      <= 1'b0;
            mem_wmask   <= '0;
            mem_wdata   <= '0;
            wb_rd       <= '0;
            wb_wen      <= 1'b0;
            wb_data     <= '0;
            wb_misalign <= 1'b0;
        end else if (accept) begin
            off_q       <= ex_result[OFFW-1:0];
            size_q      <= ex_size;
            unsigned_q  <= ex_unsigned;
            load_q      <= ex_is_load;
            rd_wen_q    <= ex_rd_wen;
            mem_addr    <= {ex_result[XLEN-1:OFFW], {OFFW{1'b0}}};
            mem_we      <= ex_is_store;
            mem_wmask   <= size_mask << ex_result[OFFW-1:0];
            mem_wdata   <= ex_sdata << {ex_result[OFFW-1:0], 3'b000};
            wb_rd       <= ex_rd;
            wb_misalign <= is_mem & misalign;
            wb_wen      <= is_mem ? 1'b0 : ex_rd_wen;
            wb_data     <= is_mem ? '0 : ex_result;
        end else if ((state == WAIT) && mem_rsp_valid) begin
            wb_wen  <= load_q & rd_wen_q;
            wb_data <= load_q ? load_val : '0;
        end
    end

endmodule
